// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_pkg
// Brief   : Opcodes, compare codes and FSM encoding shared by the sequential ALU
// Revision: 1.0
// ============================================================================
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_NAND  = 4'b0110;
    localparam logic [3:0] OP_NOR   = 4'b0111;
    localparam logic [3:0] OP_CNOP  = 4'b1000;
    localparam logic [3:0] OP_CEQ   = 4'b1001;
    localparam logic [3:0] OP_CGT   = 4'b1010;
    localparam logic [3:0] OP_CLT   = 4'b1011;
    localparam logic [3:0] OP_SHRA  = 4'b1100;
    localparam logic [3:0] OP_SHLA  = 4'b1101;
    localparam logic [3:0] OP_SHRB  = 4'b1110;
    localparam logic [3:0] OP_SHLB  = 4'b1111;

    localparam logic [1:0] CMP_NOP  = 2'd0;
    localparam logic [1:0] CMP_EQ   = 2'd1;
    localparam logic [1:0] CMP_GT   = 2'd2;
    localparam logic [1:0] CMP_LT   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIV_RUN = 2'd1,
        S_DIV_FIX = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_div.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_div
// Brief   : Unsigned restoring divider, one quotient bit per cycle after start
// Revision: 1.0
// ============================================================================
module alu_seq_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quot,
    output logic             o_last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    // Dividend bits shift out of the quotient register into the remainder.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
            r_dvs  <= '0;
        end else if (i_start) begin
            r_cnt  <= CW'(WIDTH);
            r_rem  <= '0;
            r_quot <= i_dividend;
            r_dvs  <= i_divisor;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            if (!w_trial[WIDTH]) begin
                r_rem  <= w_trial[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b1};
            end else begin
                r_rem  <= w_shift[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_quot = r_quot;
    assign o_last = (r_cnt == CW'(1));

endmodule
`default_nettype wire

// File: rtl/alu_seq_top.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_top
// Brief   : Handshaked 16-function ALU with iterative signed division
// Revision: 1.0
// ============================================================================
module alu_seq_top
    import alu_seq_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter bit SHIFT_ARITH = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         ALU_FUN,
    input  logic               In_Valid,
    output logic               In_Ready,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic [2*WIDTH-1:0] Arith_Out,
    output logic               Arith_Flag,
    output logic [WIDTH-1:0]   Logic_Out,
    output logic               Logic_Flag,
    output logic [WIDTH-1:0]   CMP_Out,
    output logic               CMP_Flag,
    output logic [WIDTH-1:0]   SHIFT_Out,
    output logic               SHIFT_Flag,
    output logic               Div_By_Zero,
    output logic               Busy
);

    localparam int W2 = 2 * WIDTH;

    state_t           r_state;
    logic             r_out_valid;
    logic             r_neg;
    logic [W2-1:0]    r_arith;
    logic             r_af;
    logic [WIDTH-1:0] r_lo;
    logic             r_lf;
    logic [WIDTH-1:0] r_cmp;
    logic             r_cf;
    logic [WIDTH-1:0] r_sh;
    logic             r_sf;
    logic             r_dbz;

    logic [W2-1:0]    w_a_ext;
    logic [W2-1:0]    w_b_ext;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_quot;
    logic [W2-1:0]    w_q_ext;
    logic [W2-1:0]    w_div_res;
    logic             w_div_last;
    logic             w_accept;
    logic             w_div_start;
    logic             w_fill_a;
    logic             w_fill_b;

    logic [W2-1:0]    w_arith;
    logic             w_af;
    logic [WIDTH-1:0] w_lo;
    logic             w_lf;
    logic [WIDTH-1:0] w_cmp;
    logic             w_cf;
    logic [WIDTH-1:0] w_sh;
    logic             w_sf;
    logic             w_dbz;

    assign In_Ready    = RST && (r_state == S_IDLE) && (!r_out_valid || Out_Ready);
    assign w_accept    = In_Valid && In_Ready;
    assign w_div_start = w_accept && (ALU_FUN == OP_DIV) && (B != '0);

    assign w_a_ext  = {{WIDTH{A[WIDTH-1]}}, A};
    assign w_b_ext  = {{WIDTH{B[WIDTH-1]}}, B};
    assign w_a_mag  = A[WIDTH-1] ? -A : A;
    assign w_b_mag  = B[WIDTH-1] ? -B : B;
    assign w_fill_a = SHIFT_ARITH ? A[WIDTH-1] : 1'b0;
    assign w_fill_b = SHIFT_ARITH ? B[WIDTH-1] : 1'b0;

    // Quotient magnitude can be 2^(WIDTH-1), so zero-extend before negating.
    assign w_q_ext   = {{WIDTH{1'b0}}, w_quot};
    assign w_div_res = r_neg ? -w_q_ext : w_q_ext;

    always_comb begin
        w_arith = '0;
        w_af    = 1'b0;
        w_lo    = '0;
        w_lf    = 1'b0;
        w_cmp   = '0;
        w_cf    = 1'b0;
        w_sh    = '0;
        w_sf    = 1'b0;
        w_dbz   = 1'b0;
        case (ALU_FUN)
            OP_ADD:  begin w_af = 1'b1; w_arith = w_a_ext + w_b_ext; end
            OP_SUB:  begin w_af = 1'b1; w_arith = w_a_ext - w_b_ext; end
            OP_MUL:  begin w_af = 1'b1; w_arith = w_a_ext * w_b_ext; end
            OP_DIV:  begin w_af = 1'b1; w_dbz = (B == '0); end
            OP_AND:  begin w_lf = 1'b1; w_lo = A & B; end
            OP_OR:   begin w_lf = 1'b1; w_lo = A | B; end
            OP_NAND: begin w_lf = 1'b1; w_lo = ~(A & B); end
            OP_NOR:  begin w_lf = 1'b1; w_lo = ~(A | B); end
            OP_CNOP: begin w_cf = 1'b1; w_cmp = {{(WIDTH-2){1'b0}}, CMP_NOP}; end
            OP_CEQ:  begin
                w_cf = 1'b1;
                if (A == B) w_cmp = {{(WIDTH-2){1'b0}}, CMP_EQ};
            end
            OP_CGT:  begin
                w_cf = 1'b1;
                if ($signed(A) > $signed(B)) w_cmp = {{(WIDTH-2){1'b0}}, CMP_GT};
            end
            OP_CLT:  begin
                w_cf = 1'b1;
                if ($signed(A) < $signed(B)) w_cmp = {{(WIDTH-2){1'b0}}, CMP_LT};
            end
            OP_SHRA: begin w_sf = 1'b1; w_sh = {w_fill_a, A[WIDTH-1:1]}; end
            OP_SHLA: begin w_sf = 1'b1; w_sh = {A[WIDTH-2:0], 1'b0}; end
            OP_SHRB: begin w_sf = 1'b1; w_sh = {w_fill_b, B[WIDTH-1:1]}; end
            OP_SHLB: begin w_sf = 1'b1; w_sh = {B[WIDTH-2:0], 1'b0}; end
            default: begin w_af = 1'b0; end
        endcase
    end

    alu_seq_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk        (CLK),
        .rst_n      (RST),
        .i_start    (w_div_start),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_quot     (w_quot),
        .o_last     (w_div_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_neg       <= 1'b0;
            r_arith     <= '0;
            r_af        <= 1'b0;
            r_lo        <= '0;
            r_lf        <= 1'b0;
            r_cmp       <= '0;
            r_cf        <= 1'b0;
            r_sh        <= '0;
            r_sf        <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            if (Out_Ready) r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_div_start) begin
                        r_neg   <= A[WIDTH-1] ^ B[WIDTH-1];
                        r_state <= S_DIV_RUN;
                    end else if (w_accept) begin
                        r_arith     <= w_arith;
                        r_af        <= w_af;
                        r_lo        <= w_lo;
                        r_lf        <= w_lf;
                        r_cmp       <= w_cmp;
                        r_cf        <= w_cf;
                        r_sh        <= w_sh;
                        r_sf        <= w_sf;
                        r_dbz       <= w_dbz;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DIV_RUN: begin
                    if (w_div_last) r_state <= S_DIV_FIX;
                end
                S_DIV_FIX: begin
                    // Hold the quotient until the previous result has been taken.
                    if (!r_out_valid || Out_Ready) begin
                        r_arith     <= w_div_res;
                        r_af        <= 1'b1;
                        r_lo        <= '0;
                        r_lf        <= 1'b0;
                        r_cmp       <= '0;
                        r_cf        <= 1'b0;
                        r_sh        <= '0;
                        r_sf        <= 1'b0;
                        r_dbz       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Out_Valid   = r_out_valid;
    assign Arith_Out   = r_arith;
    assign Arith_Flag  = r_af;
    assign Logic_Out   = r_lo;
    assign Logic_Flag  = r_lf;
    assign CMP_Out     = r_cmp;
    assign CMP_Flag    = r_cf;
    assign SHIFT_Out   = r_sh;
    assign SHIFT_Flag  = r_sf;
    assign Div_By_Zero = r_dbz;
    assign Busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_top.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_seq_top
// Brief   : Directed and random checks of alu_seq_top against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_alu_seq_top;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic [31:0] arith;
        logic        af;
        logic [15:0] lo;
        logic        lf;
        logic [15:0] cmp;
        logic        cf;
        logic [15:0] sh;
        logic        sf;
        logic        dbz;
    } res_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [3:0]  ALU_FUN = '0;
    logic        In_Valid = 1'b0;
    logic        Out_Ready = 1'b1;
    logic        In_Ready;
    logic        Out_Valid;
    logic [31:0] Arith_Out;
    logic        Arith_Flag;
    logic [15:0] Logic_Out;
    logic        Logic_Flag;
    logic [15:0] CMP_Out;
    logic        CMP_Flag;
    logic [15:0] SHIFT_Out;
    logic        SHIFT_Flag;
    logic        Div_By_Zero;
    logic        Busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq_top #(
        .WIDTH       (WIDTH),
        .SHIFT_ARITH (1'b0)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .A           (A),
        .B           (B),
        .ALU_FUN     (ALU_FUN),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .Arith_Out   (Arith_Out),
        .Arith_Flag  (Arith_Flag),
        .Logic_Out   (Logic_Out),
        .Logic_Flag  (Logic_Flag),
        .CMP_Out     (CMP_Out),
        .CMP_Flag    (CMP_Flag),
        .SHIFT_Out   (SHIFT_Out),
        .SHIFT_Flag  (SHIFT_Flag),
        .Div_By_Zero (Div_By_Zero),
        .Busy        (Busy)
    );

    initial forever #5 CLK = ~CLK;

    // Reference: what one operation must produce, straight from the function map.
    function automatic res_t model_op(input logic [3:0] f, input logic [15:0] a,
                                      input logic [15:0] b);
        res_t        r;
        int          sa;
        int          sb;
        logic [15:0] t;
        r  = '0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        t  = '0;
        case (f)
            4'h0: begin r.af = 1'b1; r.arith = 32'(sa + sb); end
            4'h1: begin r.af = 1'b1; r.arith = 32'(sa - sb); end
            4'h2: begin r.af = 1'b1; r.arith = 32'(sa * sb); end
            4'h3: begin
                r.af = 1'b1;
                if (sb == 0) r.dbz = 1'b1;
                else r.arith = 32'(sa / sb);
            end
            4'h4: begin r.lf = 1'b1; r.lo = a & b; end
            4'h5: begin r.lf = 1'b1; r.lo = a | b; end
            4'h6: begin r.lf = 1'b1; r.lo = ~(a & b); end
            4'h7: begin r.lf = 1'b1; r.lo = ~(a | b); end
            4'h8: begin r.cf = 1'b1; end
            4'h9: begin r.cf = 1'b1; r.cmp = (sa == sb) ? 16'd1 : 16'd0; end
            4'hA: begin r.cf = 1'b1; r.cmp = (sa > sb) ? 16'd2 : 16'd0; end
            4'hB: begin r.cf = 1'b1; r.cmp = (sa < sb) ? 16'd3 : 16'd0; end
            4'hC: begin r.sf = 1'b1; t = a >> 1; r.sh = t; end
            4'hD: begin r.sf = 1'b1; t = a << 1; r.sh = t; end
            4'hE: begin r.sf = 1'b1; t = b >> 1; r.sh = t; end
            default: begin r.sf = 1'b1; t = b << 1; r.sh = t; end
        endcase
        return r;
    endfunction

    // Behavioural model state: cycles left on a division, pending quotient, output view.
    int   m_left = 0;
    logic m_ov = 1'b0;
    res_t m_out = '0;
    res_t m_div = '0;

    initial begin
        logic acc;
        logic wrote;
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                m_left = 0;
                m_ov   = 1'b0;
                m_out  = '0;
                m_div  = '0;
            end else begin
                acc   = In_Valid && (m_left == 0) && (!m_ov || Out_Ready);
                wrote = 1'b0;
                if (m_left > 1) begin
                    m_left = m_left - 1;
                end else if (m_left == 1) begin
                    if (!m_ov || Out_Ready) begin
                        m_out  = m_div;
                        wrote  = 1'b1;
                        m_left = 0;
                    end
                end else if (acc) begin
                    if (ALU_FUN == 4'h3 && B != 16'h0) begin
                        m_div  = model_op(ALU_FUN, A, B);
                        m_left = WIDTH + 1;
                    end else begin
                        m_out = model_op(ALU_FUN, A, B);
                        wrote = 1'b1;
                    end
                end
                if (wrote) m_ov = 1'b1;
                else if (Out_Ready) m_ov = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        res_t act;
        logic exp_ir;
        forever begin
            @(negedge CLK);
            act = {Arith_Out, Arith_Flag, Logic_Out, Logic_Flag, CMP_Out, CMP_Flag,
                   SHIFT_Out, SHIFT_Flag, Div_By_Zero};
            exp_ir = RST && (m_left == 0) && (!m_ov || Out_Ready);
            n_cmp++;
            if (act !== m_out) begin
                n_err++;
                $display("FAIL results @%0t: got %h expected %h", $time, act, m_out);
            end
            n_cmp++;
            if (Out_Valid !== m_ov) begin
                n_err++;
                $display("FAIL out_valid @%0t: got %b expected %b", $time, Out_Valid, m_ov);
            end
            n_cmp++;
            if (In_Ready !== exp_ir) begin
                n_err++;
                $display("FAIL in_ready @%0t: got %b expected %b", $time, In_Ready, exp_ir);
            end
            n_cmp++;
            if (Busy !== (m_left > 0)) begin
                n_err++;
                $display("FAIL busy @%0t: got %b expected %b", $time, Busy, (m_left > 0));
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Presents one operation and returns one time unit after the edge that took it.
    task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                         output int n);
        logic rdy;
        n        = 0;
        rdy      = 1'b0;
        ALU_FUN  = f;
        A        = a;
        B        = b;
        In_Valid = 1'b1;
        while (!rdy && n < 100) begin
            @(negedge CLK);
            rdy = In_Ready;
            @(posedge CLK);
            #1;
            n++;
        end
        if (!rdy) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
        end
        In_Valid = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (!Out_Valid && n < 60) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!Out_Valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL result_timeout: got no Out_Valid expected Out_Valid within 60 cycles");
        end
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        #1 RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_arith", Arith_Out, 32'h0);
        chk("rst_in_ready", {31'b0, In_Ready}, 32'h0);
        chk("rst_out_valid", {31'b0, Out_Valid}, 32'h0);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Back-to-back arithmetic, A=-13, B=-12
        issue(4'h0, 16'hFFF3, 16'hFFF4, n);
        chk("add", Arith_Out, 32'hFFFF_FFE7);
        chk("add_flag", {31'b0, Arith_Flag}, 32'h1);
        chk("add_in_ready", {31'b0, In_Ready}, 32'h1);
        issue(4'h1, 16'hFFF3, 16'hFFF4, n);
        chk("sub", Arith_Out, 32'hFFFF_FFFF);
        chk("sub_b2b", n, 32'd1);
        issue(4'h2, 16'hFFF3, 16'hFFF4, n);
        chk("mul", Arith_Out, 32'd156);
        chk("mul_logic_zero", {16'b0, Logic_Out}, 32'h0);

        // Divisions
        issue(4'h3, 16'hFFF3, 16'd4, n);
        chk("div_busy", {31'b0, Busy}, 32'h1);
        chk("div_in_ready", {31'b0, In_Ready}, 32'h0);
        wait_result(n);
        chk("div_lat", n, 32'd17);
        chk("div_m13_4", Arith_Out, 32'hFFFF_FFFD);
        issue(4'h3, 16'd24, 16'd4, n);
        wait_result(n);
        chk("div_24_4", Arith_Out, 32'd6);
        issue(4'h3, 16'd3, 16'hFFF4, n);
        wait_result(n);
        chk("div_3_m12", Arith_Out, 32'd0);
        chk("div_lat2", n, 32'd17);

        // Divide by zero, then an add clears the flag
        issue(4'h3, 16'd5, 16'd0, n);
        chk("dbz_arith", Arith_Out, 32'h0);
        chk("dbz_flag", {31'b0, Div_By_Zero}, 32'h1);
        chk("dbz_af", {31'b0, Arith_Flag}, 32'h1);
        issue(4'h0, 16'd3, 16'd4, n);
        chk("add_after_dbz", Arith_Out, 32'd7);
        chk("dbz_cleared", {31'b0, Div_By_Zero}, 32'h0);

        // Back-pressure holds the NAND result
        issue(4'h6, 16'hA30F, 16'hE369, n);
        Out_Ready = 1'b0;
        chk("nand", {16'b0, Logic_Out}, 32'h5CF6);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            chk("bp_in_ready", {31'b0, In_Ready}, 32'h0);
            chk("bp_hold", {16'b0, Logic_Out}, 32'h5CF6);
        end
        Out_Ready = 1'b1;
        issue(4'h0, 16'd1, 16'd1, n);
        chk("bp_release_accept", n, 32'd1);

        // Compare and shift
        issue(4'hA, 16'd156, 16'd124, n);
        chk("cmp_gt", {16'b0, CMP_Out}, 32'd2);
        issue(4'hF, 16'h0000, 16'h2369, n);
        chk("shl_b", {16'b0, SHIFT_Out}, 32'h46D2);
        chk("shl_flag", {31'b0, SHIFT_Flag}, 32'h1);

        // Reset in the middle of -32768 / -1
        issue(4'h3, 16'h8000, 16'hFFFF, n);
        repeat (7) begin
            @(posedge CLK);
            #1;
        end
        RST = 1'b0;
        #1;
        chk("rst_mid_arith", Arith_Out, 32'h0);
        chk("rst_mid_shift_flag", {31'b0, SHIFT_Flag}, 32'h0);
        chk("rst_mid_busy", {31'b0, Busy}, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        issue(4'h3, 16'h8000, 16'hFFFF, n);
        wait_result(n);
        chk("div_mostneg", Arith_Out, 32'd32768);

        // Random traffic with random back-pressure
        for (int i = 0; i < 1500; i++) begin
            @(posedge CLK);
            #1;
            In_Valid  = ($urandom_range(0, 9) < 7);
            ALU_FUN   = 4'($urandom_range(0, 15));
            A         = pick();
            B         = pick();
            Out_Ready = ($urandom_range(0, 3) != 0);
        end
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        repeat (30) @(posedge CLK);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
